generador_obstaculos: RTL and testbench
=======================================

GENERADOR_OBSTACULOS -- requirements
Module: generador_obstaculos

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- OFF 3'd0, WLCM 3'd1, CH 3'd2, GAME 3'd3, WL 3'd4, PA 3'd5: game-state codes.
- SEPARACION 2: ticks between obstacle insertions (1..7).
- BONO_CADA 5: every BONO_CADA-th insertion is the bonus (2..15).
- OBS_POR_MUNDO 8: obstacles dodged per world advance (1..15).
- LFSR_SEED 8'hA5: LFSR reset value, nonzero.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_obstaculos, in, 1: obstacle tick; all state updates on rising edge.
- rst, in, 1: asynchronous, active-high reset.
- presente, in, 3: current game state.
- display_obs, out, 21: [20:14] entry digit, [13:7] middle digit, [6:0] hero digit; 7-seg codes.
- mundo, out, 2: world index 0..3; 3 means win.
- esquivados, out, 4: obstacles dodged in the current world.
- nuevo_mundo, out, 1: one-tick pulse when mundo increments.

Function
REQ-003 All outputs and state SHALL be registered and update only on rising clk_obstaculos or on rst.
- This leaves display_obs stable at the falling edge, where the downstream collision stage samples it.

REQ-004 Pattern table SHALL be, index 0..8:
- 1100011, 1011100, 0001001, 0011000, 0100001, 0100000, 1000000, 0001000, 1010000.
- BLANK = 0000000. BONO = 1111111.

REQ-005 The 8-bit LFSR SHALL advance every tick except in PA: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.

REQ-006 The obstacle index SHALL be the pre-advance lfsr[3:0] if that value is below 9, else lfsr[3:0]-9.

REQ-007 In GAME, every tick SHALL shift: [6:0]<=[13:7], [13:7]<=[20:14], [20:14]<=entry.

REQ-008 Spacing counter cnt_sep (3 bits) SHALL operate as follows:
- If cnt_sep==0: entry is an insertion and cnt_sep<=SEPARACION-1.
- Otherwise: entry=BLANK and cnt_sep decrements.

REQ-009 Bonus counter cnt_bono (4 bits) SHALL increment on each insertion.
- When the incremented value equals BONO_CADA, entry=BONO and cnt_bono<=0.
- Otherwise entry=table[index].

REQ-010 When mundo==3, entry SHALL be BLANK regardless of cnt_sep, with no cnt_bono change. Shifting continues.

REQ-011 Dodge counting: in GAME, a tick whose outgoing [6:0] is neither BLANK nor BONO SHALL count as a dodge.
- If esquivados+1==OBS_POR_MUNDO and mundo<3: esquivados<=0, mundo<=mundo+1, nuevo_mundo<=1.
- Otherwise: esquivados<=esquivados+1.
- At mundo==3: esquivados holds and mundo saturates.

REQ-012 nuevo_mundo SHALL be 0 on every tick not covered by REQ-011.

REQ-013 In WL and PA, display_obs, mundo, esquivados, cnt_sep and cnt_bono SHALL hold. Leaving PA for GAME resumes with no lost or duplicated tick.

REQ-014 In OFF, WLCM, CH and any undefined presente code:
- display_obs<=0, mundo<=0, esquivados<=0, cnt_sep<=0, cnt_bono<=0.
- The first GAME tick after CH therefore inserts immediately.

REQ-015 Insertion and dodge counting on the same tick SHALL both take effect.

Reset
REQ-016 On rst high, asynchronously:
- display_obs=0, mundo=0, esquivados=0, nuevo_mundo=0.
- cnt_sep=0, cnt_bono=0, lfsr=LFSR_SEED.

REQ-017 rst asserted mid-GAME SHALL clear all state within the same cycle. The first tick after release behaves as the first GAME tick.

Verification
REQ-018 Reset, presente=GAME, tick 1 -> display_obs[20:14]=0100000 (index 5 from seed A5). Tick 2 -> [13:7]=0100000, [20:14]=0. Tick 3 -> [6:0]=0100000 and a new entry is inserted.

REQ-019 GAME, 5 insertions with defaults -> the 5th entry is 1111111. Its exit from [6:0] leaves esquivados unchanged.

REQ-020 Run GAME until 8 non-bonus obstacles exit -> mundo 0->1, esquivados 7->0, nuevo_mundo high exactly one tick. Continue to mundo=3 -> entries are BLANK only, and display_obs reaches 0 within 3 ticks.

REQ-021 GAME, then PA for 10 ticks, then GAME -> display_obs and lfsr are identical before and after the pause. The next tick matches a no-pause reference.

REQ-022 GAME, then WL -> display_obs frozen. Then CH -> display_obs=0, mundo=0. The first GAME tick inserts an obstacle.

REQ-023 rst pulsed between clock edges during GAME -> outputs clear immediately. After release, tick 1 reproduces REQ-018.

Source files
------------

// File: rtl/generador_obstaculos.sv
// Obstacle generator: scrolls a three-digit 7-segment obstacle lane, inserting
// LFSR-selected patterns or a periodic bonus, and tracks dodges and world advances.
module generador_obstaculos #(
  parameter logic [2:0] OFF           = 3'd0,
  parameter logic [2:0] WLCM          = 3'd1,
  parameter logic [2:0] CH            = 3'd2,
  parameter logic [2:0] GAME          = 3'd3,
  parameter logic [2:0] WL            = 3'd4,
  parameter logic [2:0] PA            = 3'd5,
  parameter int         SEPARACION    = 2,
  parameter int         BONO_CADA     = 5,
  parameter int         OBS_POR_MUNDO = 8,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic        clk_obstaculos,
  input  logic        rst,
  input  logic [2:0]  presente,
  output logic [20:0] display_obs,
  output logic [1:0]  mundo,
  output logic [3:0]  esquivados,
  output logic        nuevo_mundo
);

  localparam logic [6:0] BLANK      = 7'b0000000;
  localparam logic [6:0] BONO       = 7'b1111111;
  localparam logic [2:0] SEP_RELOAD = 3'(SEPARACION - 1);
  localparam logic [3:0] BONO_LIM   = 4'(BONO_CADA);
  localparam logic [3:0] OBS_LIM    = 4'(OBS_POR_MUNDO);
  localparam logic [1:0] MUNDO_WIN  = 2'd3;

  typedef enum logic [1:0] {
    MODO_JUEGO,
    MODO_CONGELA,
    MODO_LIMPIA
  } modo_t;

  logic [7:0] lfsr;
  logic [2:0] cnt_sep;
  logic [3:0] cnt_bono;

  modo_t      modo;
  logic [7:0] lfsr_next;
  logic [3:0] obs_idx;
  logic [3:0] bono_inc;
  logic [6:0] entry;
  logic [2:0] sep_next;
  logic [3:0] bono_next;
  logic [6:0] salida;
  logic       es_obstaculo;

  function automatic logic [6:0] patron(input logic [3:0] idx);
    logic [6:0] p;
    case (idx)
      4'd0:    p = 7'b1100011;
      4'd1:    p = 7'b1011100;
      4'd2:    p = 7'b0001001;
      4'd3:    p = 7'b0011000;
      4'd4:    p = 7'b0100001;
      4'd5:    p = 7'b0100000;
      4'd6:    p = 7'b1000000;
      4'd7:    p = 7'b0001000;
      4'd8:    p = 7'b1010000;
      default: p = BLANK;
    endcase
    return p;
  endfunction

  // Undefined state codes fall into the clearing group alongside OFF/WLCM/CH.
  always_comb begin
    modo = MODO_LIMPIA;
    case (presente)
      GAME:           modo = MODO_JUEGO;
      WL, PA:         modo = MODO_CONGELA;
      OFF, WLCM, CH:  modo = MODO_LIMPIA;
      default:        modo = MODO_LIMPIA;
    endcase
  end

  // Next lane entry and counter values, all derived from the pre-tick state.
  always_comb begin
    lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    obs_idx   = (lfsr[3:0] < 4'd9) ? lfsr[3:0] : lfsr[3:0] - 4'd9;
    bono_inc  = cnt_bono + 4'd1;
    entry     = BLANK;
    bono_next = cnt_bono;
    sep_next  = (cnt_sep == 3'd0) ? SEP_RELOAD : cnt_sep - 3'd1;
    if ((cnt_sep == 3'd0) && (mundo != MUNDO_WIN)) begin
      if (bono_inc == BONO_LIM) begin
        entry     = BONO;
        bono_next = 4'd0;
      end else begin
        entry     = patron(obs_idx);
        bono_next = bono_inc;
      end
    end
    salida       = display_obs[6:0];
    es_obstaculo = (salida != BLANK) && (salida != BONO);
  end

  always_ff @(posedge clk_obstaculos or posedge rst) begin
    if (rst) begin
      display_obs <= '0;
      mundo       <= '0;
      esquivados  <= '0;
      nuevo_mundo <= 1'b0;
      cnt_sep     <= '0;
      cnt_bono    <= '0;
      lfsr        <= LFSR_SEED;
    end else begin
      nuevo_mundo <= 1'b0;
      if (presente != PA) begin
        lfsr <= lfsr_next;
      end
      case (modo)
        MODO_JUEGO: begin
          display_obs <= {entry, display_obs[20:7]};
          cnt_sep     <= sep_next;
          cnt_bono    <= bono_next;
          // Once the last world is reached the dodge tally stops moving.
          if (es_obstaculo && (mundo != MUNDO_WIN)) begin
            if (esquivados + 4'd1 == OBS_LIM) begin
              esquivados  <= 4'd0;
              mundo       <= mundo + 2'd1;
              nuevo_mundo <= 1'b1;
            end else begin
              esquivados <= esquivados + 4'd1;
            end
          end
        end
        MODO_CONGELA: begin
        end
        default: begin
          display_obs <= '0;
          mundo       <= '0;
          esquivados  <= '0;
          cnt_sep     <= '0;
          cnt_bono    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_generador_obstaculos.sv
// Randomized bench for generador_obstaculos against a digit-level game model.
module tb_generador_obstaculos;

  localparam logic [2:0] OFF = 3'd0, WLCM = 3'd1, CH = 3'd2, GAME = 3'd3, WL = 3'd4, PA = 3'd5;
  localparam int SEP = 2, BONO_N = 5, OBS_N = 8;

  logic        clk_obstaculos = 1'b0;
  logic        rst;
  logic [2:0]  presente;
  logic [20:0] display_obs;
  logic [1:0]  mundo;
  logic [3:0]  esquivados;
  logic        nuevo_mundo;

  int total = 0;
  int bad = 0;

  int tabla [9] = '{7'b1100011, 7'b1011100, 7'b0001001, 7'b0011000, 7'b0100001,
                    7'b0100000, 7'b1000000, 7'b0001000, 7'b1010000};

  // Digit 0 is the hero position, digit 2 the entry position.
  int m_dig [3];
  int m_lfsr, m_mundo, m_esq, m_nm, m_game_ticks, m_inserts;

  generador_obstaculos dut (
    .clk_obstaculos(clk_obstaculos),
    .rst(rst),
    .presente(presente),
    .display_obs(display_obs),
    .mundo(mundo),
    .esquivados(esquivados),
    .nuevo_mundo(nuevo_mundo)
  );

  always #5 clk_obstaculos = ~clk_obstaculos;

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) m_dig[i] = 0;
    m_mundo = 0; m_esq = 0; m_nm = 0; m_game_ticks = 0; m_inserts = 0;
  endfunction

  function automatic void model_reset();
    model_clear();
    m_lfsr = 'hA5;
  endfunction

  function automatic void model_tick(input logic [2:0] st);
    int entry, salida, fb;
    m_nm = 0;
    if (st == GAME) begin
      salida = m_dig[0];
      entry = 0;
      if (m_mundo != 3 && (m_game_ticks % SEP) == 0) begin
        m_inserts++;
        entry = ((m_inserts % BONO_N) == 0) ? 127 : tabla[(m_lfsr & 15) % 9];
      end
      m_game_ticks++;
      m_dig[0] = m_dig[1];
      m_dig[1] = m_dig[2];
      m_dig[2] = entry;
      if (salida != 0 && salida != 127 && m_mundo != 3) begin
        if (m_esq + 1 == OBS_N) begin
          m_esq = 0; m_mundo++; m_nm = 1;
        end else begin
          m_esq++;
        end
      end
    end else if (st != WL && st != PA) begin
      model_clear();
    end
    if (st != PA) begin
      fb = int'(^(m_lfsr & 32'hB8));
      m_lfsr = ((m_lfsr << 1) | fb) & 255;
    end
  endfunction

  function automatic logic [27:0] model_outs();
    return {7'(m_dig[2]), 7'(m_dig[1]), 7'(m_dig[0]), 2'(m_mundo), 4'(m_esq), 1'(m_nm)};
  endfunction

  task automatic step(input logic [2:0] st);
    presente = st;
    @(posedge clk_obstaculos);
    model_tick(st);
    @(negedge clk_obstaculos);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk_obstaculos);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    presente = GAME;
    rst = 1'b1;
    @(negedge clk_obstaculos);
    model_reset();
    total++;
    if ({display_obs, mundo, esquivados, nuevo_mundo} !== model_outs()) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%h exp=%h", {display_obs, mundo, esquivados, nuevo_mundo}, model_outs());
    end
    @(negedge clk_obstaculos);
    total++;
    if (display_obs !== 21'd0) begin
      bad++;
      $display("[TB] FAIL reset_held_display got=%h exp=0", display_obs);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_ticks();
    do_reset();
    step(GAME);
    total++;
    if (display_obs[20:14] !== 7'b0100000 || {display_obs, mundo, esquivados, nuevo_mundo} !== model_outs()) begin
      bad++;
      $display("[TB] FAIL first_tick1 got=%h exp=%h", {display_obs, mundo, esquivados, nuevo_mundo}, model_outs());
    end
    step(GAME);
    total++;
    if (display_obs[13:7] !== 7'b0100000 || display_obs[20:14] !== 7'd0) begin
      bad++;
      $display("[TB] FAIL first_tick2 got=%h exp=%h", display_obs, {7'd0, 7'b0100000, 7'd0});
    end
    step(GAME);
    total++;
    if (display_obs[6:0] !== 7'b0100000 || display_obs[20:14] === 7'd0 ||
        {display_obs, mundo, esquivados, nuevo_mundo} !== model_outs()) begin
      bad++;
      $display("[TB] FAIL first_tick3 got=%h exp=%h", {display_obs, mundo, esquivados, nuevo_mundo}, model_outs());
    end
  endtask

  task automatic test_bonus();
    logic [3:0] prev_esq;
    do_reset();
    repeat (9) step(GAME);
    total++;
    if (display_obs[20:14] !== 7'b1111111) begin
      bad++;
      $display("[TB] FAIL bonus_entry got=%b exp=1111111", display_obs[20:14]);
    end
    repeat (2) step(GAME);
    total++;
    if (display_obs[6:0] !== 7'b1111111 || esquivados !== 4'd4) begin
      bad++;
      $display("[TB] FAIL bonus_at_hero got=%b/%0d exp=1111111/4", display_obs[6:0], esquivados);
    end
    prev_esq = esquivados;
    step(GAME);
    total++;
    if (esquivados !== prev_esq || {display_obs, mundo, esquivados, nuevo_mundo} !== model_outs()) begin
      bad++;
      $display("[TB] FAIL bonus_exit_no_dodge got=%0d exp=%0d", esquivados, prev_esq);
    end
  endtask

  task automatic test_worlds();
    int pulses = 0;
    logic prev_nm = 1'b0;
    logic [3:0] prev_esq = 4'd0;
    do_reset();
    for (int i = 0; i < 400 && mundo != 2'd3; i++) begin
      prev_esq = esquivados;
      step(GAME);
      total++;
      if ({display_obs, mundo, esquivados, nuevo_mundo} !== model_outs()) begin
        bad++;
        $display("[TB] FAIL worlds_tick%0d got=%h exp=%h", i, {display_obs, mundo, esquivados, nuevo_mundo}, model_outs());
      end
      if (nuevo_mundo === 1'b1) begin
        pulses++;
        total++;
        if (prev_nm === 1'b1 || prev_esq !== 4'(OBS_N - 1) || esquivados !== 4'd0) begin
          bad++;
          $display("[TB] FAIL world_pulse prev_nm=%b esq=%0d->%0d exp 0,%0d->0", prev_nm, prev_esq, esquivados, OBS_N - 1);
        end
      end
      prev_nm = nuevo_mundo;
    end
    total++;
    if (mundo !== 2'd3 || pulses != 3) begin
      bad++;
      $display("[TB] FAIL worlds_reach_win got mundo=%0d pulses=%0d exp mundo=3 pulses=3", mundo, pulses);
    end
    repeat (3) step(GAME);
    total++;
    if (display_obs !== 21'd0) begin
      bad++;
      $display("[TB] FAIL win_lane_clears got=%h exp=0", display_obs);
    end
    repeat (5) step(GAME);
    total++;
    if ({display_obs, mundo, esquivados, nuevo_mundo} !== model_outs() || mundo !== 2'd3) begin
      bad++;
      $display("[TB] FAIL win_holds got=%h exp=%h", {display_obs, mundo, esquivados, nuevo_mundo}, model_outs());
    end
  endtask

  task automatic test_pause();
    logic [27:0] snap;
    do_reset();
    repeat ($urandom_range(3, 12)) step(GAME);
    snap = {display_obs, mundo, esquivados, nuevo_mundo};
    for (int i = 0; i < 10; i++) begin
      step(PA);
      total++;
      if ({display_obs, mundo, esquivados} !== snap[27:1] || nuevo_mundo !== 1'b0) begin
        bad++;
        $display("[TB] FAIL pause_hold%0d got=%h exp=%h", i, {display_obs, mundo, esquivados}, snap[27:1]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(GAME);
      total++;
      if ({display_obs, mundo, esquivados, nuevo_mundo} !== model_outs()) begin
        bad++;
        $display("[TB] FAIL pause_resume%0d got=%h exp=%h", i, {display_obs, mundo, esquivados, nuevo_mundo}, model_outs());
      end
    end
  endtask

  task automatic test_wl_ch();
    logic [20:0] snap;
    do_reset();
    repeat ($urandom_range(4, 15)) step(GAME);
    snap = display_obs;
    repeat (4) step(WL);
    total++;
    if (display_obs !== snap || {display_obs, mundo, esquivados, nuevo_mundo} !== model_outs()) begin
      bad++;
      $display("[TB] FAIL wl_freeze got=%h exp=%h", display_obs, snap);
    end
    step(CH);
    total++;
    if (display_obs !== 21'd0 || mundo !== 2'd0 || esquivados !== 4'd0) begin
      bad++;
      $display("[TB] FAIL ch_clear got=%h/%0d/%0d exp=0/0/0", display_obs, mundo, esquivados);
    end
    step(GAME);
    total++;
    if (display_obs[20:14] === 7'd0 || {display_obs, mundo, esquivados, nuevo_mundo} !== model_outs()) begin
      bad++;
      $display("[TB] FAIL ch_first_insert got=%h exp=%h", {display_obs, mundo, esquivados, nuevo_mundo}, model_outs());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (7) step(GAME);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({display_obs, mundo, esquivados, nuevo_mundo} !== 28'd0) begin
      bad++;
      $display("[TB] FAIL async_reset got=%h exp=0", {display_obs, mundo, esquivados, nuevo_mundo});
    end
    model_reset();
    #1 rst = 1'b0;
    step(GAME);
    total++;
    if (display_obs[20:14] !== 7'b0100000 || {display_obs, mundo, esquivados, nuevo_mundo} !== model_outs()) begin
      bad++;
      $display("[TB] FAIL async_reset_restart got=%h exp=%h", {display_obs, mundo, esquivados, nuevo_mundo}, model_outs());
    end
  endtask

  task automatic test_random();
    logic [2:0] st;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 9) < 6) ? GAME : 3'($urandom_range(0, 7));
      step(st);
      total++;
      if ({display_obs, mundo, esquivados, nuevo_mundo} !== model_outs()) begin
        bad++;
        $display("[TB] FAIL random_tick%0d st=%0d got=%h exp=%h", i, st, {display_obs, mundo, esquivados, nuevo_mundo}, model_outs());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    presente = OFF;
    test_reset();
    test_first_ticks();
    test_bonus();
    test_worlds();
    test_pause();
    test_wl_ch();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
